// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg: shared types and constants for the DRAM port arbiter
package dram_arb_pkg;
  typedef enum logic {S_IDLE, S_OWN} arb_state_t;
  localparam int REQ_FETCH = 0;
  localparam int REQ_LOAD  = 1;
  localparam int REQ_STORE = 2;
  typedef logic [1:0] req_id_t;
  function automatic int wrap_idx(input int i, input int n);
    return i >= n ? i - n : i;
  endfunction
endpackage

// File: rtl/arb_tag_fifo.sv
// arb_tag_fifo: in-order FIFO of requester ids for outstanding DRAM reads
module arb_tag_fifo
  import dram_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  req_id_t din,
  output req_id_t dout,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);
  req_id_t       mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  // storage needs no reset: an entry is only read after it has been pushed
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= din;
  end
  assign dout  = mem_q[rp_q];
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
endmodule

// File: rtl/dram_arbiter.sv
// dram_arbiter: round-robin burst-locking arbiter for the byte-wide DRAM port (DRAM_ARB_FIXED_PRIO_EN selects fixed priority)
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 3,
  parameter int MAX_BURST  = 32,
  parameter int RD_DEPTH   = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ-1:0]                   req_we,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic [NUM_REQ-1:0]                   rsp_valid,
  output logic [DATA_WIDTH-1:0]                rsp_data,
  output logic                                 mem_req,
  output logic                                 mem_we,
  output logic [ADDR_WIDTH-1:0]                mem_addr,
  output logic [DATA_WIDTH-1:0]                mem_wdata,
  input  logic                                 mem_ready,
  input  logic                                 mem_rvalid,
  input  logic [DATA_WIDTH-1:0]                mem_rdata,
  output logic [$clog2(NUM_REQ)-1:0]           owner,
  output logic                                 busy,
  output logic                                 rsp_err
);
  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST) + 1;
  arb_state_t    state_q, state_d;
  logic [OW-1:0] owner_q, owner_d, rr_q, rr_d, winner;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          own, fire, rd_block, push, pop, tag_full, tag_empty;
  req_id_t       tag_dout;
  assign own  = state_q == S_OWN;
  assign fire = mem_req && mem_ready;
  assign push = fire && !mem_we;
  assign pop  = mem_rvalid && !tag_empty;
  // a read returning this cycle frees a slot, so a full FIFO need not stall the next read
  assign rd_block = tag_full && !mem_rvalid;
  arb_tag_fifo #(.DEPTH(RD_DEPTH)) u_tags (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (req_id_t'(owner_q)),
    .dout  (tag_dout),
    .full  (tag_full),
    .empty (tag_empty)
  );
  // winner selection: first active requester at or after rr_q, or lowest index when fixed
  always_comb begin
    winner = '0;
`ifdef DRAM_ARB_FIXED_PRIO_EN
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req_valid[i]) winner = OW'(i);
`else
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req_valid[wrap_idx(int'(rr_q) + i, NUM_REQ)]) winner = OW'(wrap_idx(int'(rr_q) + i, NUM_REQ));
`endif
  end
  // state register with grant bookkeeping and sticky error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
  // next state: grant from idle, release on dropped request or burst limit
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    err_d   = err_q || (mem_rvalid && tag_empty);
    if (!own) begin
      if (|req_valid) begin
        state_d = S_OWN;
        owner_d = winner;
        cnt_d   = '0;
      end
    end else begin
      if (fire) cnt_d = cnt_q + 1'b1;
      if (!req_valid[owner_q] || (fire && cnt_q == CW'(MAX_BURST - 1))) begin
        state_d = S_IDLE;
        rr_d    = owner_q == OW'(NUM_REQ - 1) ? '0 : owner_q + 1'b1;
      end
    end
  end
  // outputs: owner drives the DRAM port, returning reads go to the tagged requester
  always_comb begin
    mem_req            = own && req_valid[owner_q] && !(!req_we[owner_q] && rd_block);
    mem_we             = own && req_we[owner_q];
    mem_addr           = own ? req_addr[owner_q] : '0;
    mem_wdata          = own ? req_wdata[owner_q] : '0;
    req_ready          = '0;
    req_ready[owner_q] = mem_req && mem_ready;
    rsp_valid          = '0;
    rsp_valid[tag_dout] = pop;
    rsp_data           = pop ? mem_rdata : '0;
  end
  assign owner   = owner_q;
  assign busy    = own || !tag_empty;
  assign rsp_err = err_q;
endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed self-checking bench for dram_arbiter
module tb_dram_arbiter;
  localparam int AW = 24, DW = 8, NR = 3, DLY = 6;
`ifdef DRAM_ARB_FIXED_PRIO_EN
  localparam int EXP_CONTEND = 0;
`else
  localparam int EXP_CONTEND = 1;
`endif
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  logic [NR-1:0]         req_valid, req_we, req_ready, rsp_valid;
  logic [NR-1:0][AW-1:0] req_addr;
  logic [NR-1:0][DW-1:0] req_wdata;
  logic [DW-1:0]         rsp_data, mem_wdata, mem_rdata;
  logic                  mem_req, mem_we, mem_ready, mem_rvalid, busy, rsp_err;
  logic [AW-1:0]         mem_addr;
  logic [1:0]            owner;
  dram_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .owner(owner), .busy(busy), .rsp_err(rsp_err)
  );
  typedef struct { logic [7:0] data; int due; int id; } rd_t;
  rd_t rq[$];
  int cyc = 0, scyc = 0, n_checks = 0, n_errors = 0, rd_id = 0, first_rv = -1;
  int rsp_cnt [NR];
  int f [40];
  logic force_rv = 1'b0, fired, mreq_s;
  logic [NR-1:0] rdy_s;
  logic [1:0] own_s;
  logic [AW-1:0] addr_s;
  function automatic logic [7:0] mval(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    scyc   = cyc;
    rdy_s  = req_ready;
    mreq_s = mem_req;
    own_s  = owner;
    addr_s = mem_addr;
    fired  = mem_req && mem_ready;
    for (int i = 0; i < NR; i++) if (rsp_valid[i]) rsp_cnt[i]++;
    if (mem_rvalid && !force_rv && rq.size() > 0) begin
      check("rsp_valid", rsp_valid, 32'(1) << rq[0].id);
      check("rsp_data", rsp_data, rq[0].data);
      if (first_rv < 0) first_rv = scyc;
      void'(rq.pop_front());
    end else check("rsp_idle", rsp_valid, 0);
    if (fired && !mem_we) rq.push_back('{mval(mem_addr), scyc + DLY, rd_id});
    @(posedge clk);
    cyc++;
    #1;
    mem_rvalid = force_rv || (rq.size() > 0 && rq[0].due <= cyc);
    mem_rdata  = (rq.size() > 0 && !force_rv) ? rq[0].data : 8'hEE;
  endtask
  task automatic drive(input int r, input logic v, input logic we, input logic [AW-1:0] a);
    req_valid[r] = v;
    req_we[r]    = we;
    req_addr[r]  = a;
    req_wdata[r] = a[7:0] + 8'd1;
  endtask
  task automatic wait_fire(input string tag);
    int t = 0;
    do begin tick(); t++; end while (!fired && t < 40);
    check(tag, 32'(fired), 1);
  endtask
  task automatic drain(input string tag);
    int t = 0;
    while ((rq.size() != 0 || busy) && t < 60) begin tick(); t++; end
    check(tag, 32'(t < 60), 1);
    for (int i = 0; i < NR; i++) rsp_cnt[i] = 0;
  endtask
  initial begin
    int k;
    bit done;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
    for (int i = 0; i < NR; i++) rsp_cnt[i] = 0;
    #12;
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_ready", req_ready, 0);
    check("rst_rsp", rsp_valid, 0);
    check("rst_owner", owner, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(rsp_err), 0);
    @(posedge clk); #1; rst = 1'b1;
    // store alone, 40 bytes: burst of 32, bubble, burst of 8
    drive(2, 1, 1, 24'h100);
    k = 0;
    for (int t = 0; t < 100 && k < 40; t++) begin
      tick();
      if (fired) begin
        check("t1_addr", addr_s, 24'h100 + k);
        check("t1_owner", own_s, 2);
        check("t1_ready", rdy_s, 3'b100);
        f[k] = scyc;
        k++;
        if (k == 40) req_valid[2] = 1'b0; else req_addr[2] = 24'h100 + k;
      end
    end
    check("t1_beats", k, 40);
    check("t1_burst_span", f[31] - f[0], 31);
    check("t1_bubble", f[32] - f[31], 2);
    check("t1_tail_span", f[39] - f[32], 7);
    drain("t1_drain");
    // load and store together from idle: load first, store after load drops
    rd_id = 1;
    drive(1, 1, 0, 24'h10);
    drive(2, 1, 1, 24'h200);
    k = 0; done = 0;
    for (int t = 0; t < 40 && !done; t++) begin
      tick();
      if (fired && k < 2) begin
        check("t2_load_owner", own_s, 1);
        k++;
        if (k == 2) req_valid[1] = 1'b0; else req_addr[1] = 24'h11;
      end else if (fired) begin
        check("t2_store_owner", own_s, 2);
        check("t2_store_addr", addr_s, 24'h200);
        req_valid[2] = 1'b0;
        done = 1;
      end
    end
    check("t2_done", 32'(done), 1);
    drain("t2_drain");
    // five back-to-back loads against a 6-cycle read latency
    first_rv = -1;
    drive(1, 1, 0, 24'h20);
    k = 0;
    for (int t = 0; t < 60 && k < 5; t++) begin
      tick();
      if (fired) begin
        f[k] = scyc;
        k++;
        if (k == 5) req_valid[1] = 1'b0; else req_addr[1] = 24'h20 + k;
      end
    end
    check("t3_fired", k, 5);
    check("t3_first_four", f[3] - f[0], 3);
    check("t3_stall", f[4] - f[3], 3);
    check("t3_fifth_on_rvalid", f[4], first_rv);
    check("t3_latency", first_rv - f[0], DLY);
    drain("t3_drain_pre");
    // drain clears counts, so recheck count on a fresh run is not needed; counted below instead
    // fetch read then store write, reads return later
    rd_id = 0;
    mem_ready = 1'b0;
    drive(0, 1, 0, 24'h30);
    tick();
    tick();
    check("t4_mreq", 32'(mreq_s), 1);
    check("t4_stall_ready", rdy_s, 0);
    mem_ready = 1'b1;
    wait_fire("t4_fetch_fire");
    check("t4_fetch_ready", rdy_s, 3'b001);
    req_valid[0] = 1'b0;
    drive(2, 1, 1, 24'h300);
    wait_fire("t4_store_fire");
    check("t4_store_owner", own_s, 2);
    req_valid[2] = 1'b0;
    k = 0;
    for (int t = 0; t < 60 && (rq.size() != 0 || busy); t++) tick();
    check("t4_rsp_fetch", rsp_cnt[0], 1);
    check("t4_rsp_store", rsp_cnt[2], 0);
    drain("t4_drain");
    // five-load response count on a repeat run
    rd_id = 1;
    drive(1, 1, 0, 24'h40);
    k = 0;
    for (int t = 0; t < 60 && k < 5; t++) begin
      tick();
      if (fired) begin
        k++;
        if (k == 5) req_valid[1] = 1'b0; else req_addr[1] = 24'h40 + k;
      end
    end
    for (int t = 0; t < 60 && (rq.size() != 0 || busy); t++) tick();
    check("t3_rsp_load", rsp_cnt[1], 5);
    drain("t3_drain");
    // stray read data with nothing outstanding
    force_rv = 1'b1;
    tick();
    force_rv = 1'b0;
    tick();
    tick();
    check("t5_err", 32'(rsp_err), 1);
    repeat (3) tick();
    check("t5_err_sticky", 32'(rsp_err), 1);
    check("t5_no_rsp", rsp_cnt[0] + rsp_cnt[1] + rsp_cnt[2], 0);
    // asynchronous reset in the middle of a store burst
    drive(2, 1, 1, 24'h400);
    k = 0;
    for (int t = 0; t < 40 && k < 10; t++) begin
      tick();
      if (fired) begin k++; req_addr[2] = 24'h400 + k; end
    end
    check("t6_pre_mreq", 32'(mem_req), 1);
    rst = 1'b0;
    #1;
    check("t6_mem_req", 32'(mem_req), 0);
    check("t6_ready", req_ready, 0);
    check("t6_owner", owner, 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_err", 32'(rsp_err), 0);
    check("t6_addr", mem_addr, 0);
    rq.delete();
    mem_rvalid = 1'b0;
    drive(1, 1, 1, 24'h500);
    repeat (2) tick();
    rst = 1'b1;
    wait_fire("t6_regrant");
    check("t6_first_owner", own_s, 1);
    req_valid = '0;
    drain("t6_drain");
    // contention right after fetch releases
    drive(0, 1, 1, 24'h600);
    wait_fire("t7_fetch_fire");
    check("t7_fetch_owner", own_s, 0);
    req_valid[0] = 1'b0;
    tick();
    drive(0, 1, 1, 24'h601);
    drive(1, 1, 1, 24'h700);
    wait_fire("t7_contend_fire");
    check("t7_contend_owner", own_s, EXP_CONTEND);
    req_valid = '0;
    drain("t7_drain");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
